// File: rtl/seven_seg_capture.sv
// Captures the digits of a multiplexed, active-low seven-segment display and delivers whole 4-digit BCD frames.
// Optional macro SEG_CAPTURE_BLANK_EN: the all-off pattern decodes to 4'hA (blank) instead of an error.
module seven_seg_capture #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [6:0]  SevenOut,
   input  logic [3:0]  Digit,
   output logic [15:0] bcd_value,
   output logic        frame_valid,
   output logic        seg_err
);

   typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HELD} state_t;

   localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [6:0]      seg_q;
   logic [3:0]      dig_q;
   logic [10:0]     prev_q;
   logic [3:0]      mask_q, mask_d;
   logic [3:0]      err_q, err_d;
   logic [3:0][3:0] slot_q, slot_d;
   logic [15:0]     bcd_q, bcd_d;
   logic            fv_q, fv_d;
   logic            serr_q, serr_d;

   logic [10:0]     sample;
   logic            changed, legal, stable_hit, capture;
   logic [1:0]      slot_idx;
   logic [4:0]      dec;

   function automatic logic [4:0] decode(input logic [6:0] pat);
      case (pat)
         7'b1000000: return 5'h00;
         7'b1111001: return 5'h01;
         7'b0100100: return 5'h02;
         7'b0110000: return 5'h03;
         7'b0011001: return 5'h04;
         7'b0010010: return 5'h05;
         7'b0000010: return 5'h06;
         7'b1111000: return 5'h07;
         7'b0000000: return 5'h08;
         7'b0010000: return 5'h09;
`ifdef SEG_CAPTURE_BLANK_EN
         7'b1111111: return 5'h0A;
`endif
         default:    return 5'h1F;  // error flag + 4'hF
      endcase
   endfunction

   assign sample     = {dig_q, seg_q};
   assign changed    = (sample != prev_q);
   assign legal      = (dig_q == 4'b1110) || (dig_q == 4'b1101) ||
                       (dig_q == 4'b1011) || (dig_q == 4'b0111);
   assign stable_hit = (state_q == S_SETTLE) && !changed && ((cnt_q + 8'd1) == STABLE_C);
   assign dec        = decode(seg_q);

   always_comb begin
      case (dig_q)
         4'b1101: slot_idx = 2'd1;
         4'b1011: slot_idx = 2'd2;
         4'b0111: slot_idx = 2'd3;
         default: slot_idx = 2'd0;
      endcase
   end

   // State register plus the datapath flops it controls.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (RST) begin
         state_q <= S_WAIT;
         cnt_q   <= 8'd0;
         seg_q   <= 7'h7F;
         dig_q   <= 4'hF;
         prev_q  <= {4'hF, 7'h7F};
         mask_q  <= 4'h0;
         err_q   <= 4'h0;
         // NOTE: slot storage is only four nibbles of flops, so it is reset like any other state.
         slot_q  <= '0;
         bcd_q   <= 16'h0000;
         fv_q    <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         seg_q   <= SevenOut;
         dig_q   <= Digit;
         prev_q  <= sample;
         mask_q  <= mask_d;
         err_q   <= err_d;
         slot_q  <= slot_d;
         bcd_q   <= bcd_d;
         fv_q    <= fv_d;
         serr_q  <= serr_d;
      end
   end

   // Next-state logic for the debounce FSM.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_WAIT: begin
            if (legal) begin
               state_d = S_SETTLE;
               cnt_d   = 8'd1;
            end else begin
               cnt_d   = 8'd0;
            end
         end
         S_SETTLE, S_HELD: begin
            if (changed) begin
               state_d = legal ? S_SETTLE : S_WAIT;
               cnt_d   = legal ? 8'd1 : 8'd0;
            end else if (state_q == S_SETTLE) begin
               cnt_d   = cnt_q + 8'd1;
               if (stable_hit) state_d = S_HELD;
            end
         end
         default: begin
            state_d = S_WAIT;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Output logic: slot capture and frame hand-off.
   always_comb begin
      capture = stable_hit;
      mask_d  = mask_q;
      err_d   = err_q;
      slot_d  = slot_q;
      bcd_d   = bcd_q;
      serr_d  = serr_q;
      fv_d    = 1'b0;
      if (mask_q == 4'hF) begin
         bcd_d  = slot_q;
         serr_d = |err_q;
         fv_d   = 1'b1;
         mask_d = 4'h0;
         err_d  = 4'h0;
      end
      // Applied after the clear so a coincident capture belongs to the next frame.
      if (capture) begin
         slot_d[slot_idx] = dec[3:0];
         err_d[slot_idx]  = dec[4];
         mask_d[slot_idx] = 1'b1;
      end
   end

   assign bcd_value   = bcd_q;
   assign frame_valid = fv_q;
   assign seg_err     = serr_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: expected frames are queued as digits are scanned and
// popped whenever frame_valid pulses.
module tb_seven_seg_capture;

   typedef struct packed {
      logic [15:0] bcd;
      logic        err;
   } frame_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic [6:0]  SevenOut;
   logic [3:0]  Digit;
   logic [15:0] bcd_value;
   logic        frame_valid;
   logic        seg_err;

   frame_t exp_q[$];
   int     n_cmp = 0;
   int     n_err = 0;

   seven_seg_capture #(.STABLE_CYCLES(4)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .SevenOut   (SevenOut),
      .Digit      (Digit),
      .bcd_value  (bcd_value),
      .frame_valid(frame_valid),
      .seg_err    (seg_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Drives one anode position with a pattern for exactly `cycles` clocks (called at a negedge).
   task automatic show(input int pos, input logic [6:0] pat, input int cycles);
      logic [3:0] one;
      one      = 4'b0001 << pos;
      Digit    = ~one;
      SevenOut = pat;
      repeat (cycles) @(negedge CLK);
   endtask

   task automatic gap(input logic [3:0] dig, input int cycles);
      Digit    = dig;
      SevenOut = seg(8);
      repeat (cycles) @(negedge CLK);
   endtask

   task automatic expect_frame(input logic [15:0] bcd, input logic err);
      frame_t f;
      f.bcd = bcd;
      f.err = err;
      exp_q.push_back(f);
   endtask

   // Scans a 4-digit value, leftmost digit first, each digit held `cycles` clocks.
   task automatic scan(input logic [15:0] v, input int cycles);
      logic [15:0] t;
      t = v;
      for (int p = 3; p >= 0; p--) show(p, seg(int'(t[p*4 +: 4])), cycles);
   endtask

   always @(negedge CLK) begin
      if (frame_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_frame", 32'd1, 32'd0);
         end else begin
            frame_t f;
            f = exp_q.pop_front();
            check("bcd_value", 32'(bcd_value), 32'(f.bcd));
            check("seg_err", 32'(seg_err), 32'(f.err));
         end
      end
   end

   initial begin
      RST      = 1'b1;
      Digit    = 4'hF;
      SevenOut = 7'h7F;
      repeat (3) @(negedge CLK);
      check("rst_bcd", 32'(bcd_value), 32'h0);
      check("rst_fv", 32'(frame_valid), 32'h0);
      check("rst_err", 32'(seg_err), 32'h0);
      RST = 1'b0;

      // Basic scan of 1234.
      expect_frame(16'h1234, 1'b0);
      scan(16'h1234, 10);

      // Digit 0 flashes "8" for two cycles before settling on "3".
      expect_frame(16'h9873, 1'b0);
      show(3, seg(9), 10);
      show(2, seg(8), 10);
      show(1, seg(7), 10);
      show(0, seg(8), 2);
      show(0, seg(3), 10);

      // Stability boundary: 3 cycles is too short, exactly 4 captures.
      expect_frame(16'h3502, 1'b0);
      show(3, seg(3), 4);
      show(2, seg(1), 3);
      show(2, seg(5), 4);
      show(1, seg(0), 4);
      show(0, seg(2), 4);
      repeat (4) @(negedge CLK);

      // Undecodable pattern on digit 2, then a clean frame clears the error.
      expect_frame(16'h5F79, 1'b1);
      show(3, seg(5), 10);
      show(2, 7'b0110110, 10);
      show(1, seg(7), 10);
      show(0, seg(9), 10);
      repeat (10) @(negedge CLK);
      check("hold_bcd", 32'(bcd_value), 32'h5F79);
      check("hold_err", 32'(seg_err), 32'h1);
      expect_frame(16'h5678, 1'b0);
      scan(16'h5678, 10);

      // Illegal anode values held between digits must not capture.
      expect_frame(16'h2468, 1'b0);
      show(3, seg(2), 10);
      gap(4'b1111, 20);
      show(2, seg(4), 10);
      gap(4'b0011, 20);
      show(1, seg(6), 10);
      gap(4'b0000, 20);
      show(0, seg(8), 10);

      // Reset after three captures discards the partial frame.
      show(3, seg(7), 10);
      show(2, seg(7), 10);
      show(1, seg(7), 10);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      check("midrst_bcd", 32'(bcd_value), 32'h0);
      check("midrst_err", 32'(seg_err), 32'h0);
      RST = 1'b0;
      expect_frame(16'h4321, 1'b0);
      show(0, seg(1), 10);
      show(1, seg(2), 10);
      show(2, seg(3), 10);
      show(3, seg(4), 10);

      // All-segments-off pattern on digit 3.
`ifdef SEG_CAPTURE_BLANK_EN
      expect_frame(16'hA042, 1'b0);
`else
      expect_frame(16'hF042, 1'b1);
`endif
      show(3, 7'b1111111, 10);
      show(2, seg(0), 10);
      show(1, seg(4), 10);
      show(0, seg(2), 10);

      repeat (10) @(negedge CLK);
      check("frames_pending", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
